// File: rtl/activation_interpolator_pipe.sv
// Piecewise-linear activation function: a signed register LUT addressed by the top bits of
// the offset sample, linearly interpolated on the low bits, in a three-stage stallable pipeline.
module activation_interpolator_pipe #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lut_we,
    input  logic [ADDR_W-1:0]        lut_addr,
    input  logic signed [DATA_W-1:0] lut_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic                     in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_y
);

    localparam int REM_W  = DATA_W - ADDR_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PROD_W = DATA_W + REM_W + 2;
    localparam logic [DATA_W-1:0] BIAS = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] lut [DEPTH];

    logic                     advance;
    logic [DATA_W-1:0]        u;
    logic [ADDR_W-1:0]        idx;
    logic [ADDR_W-1:0]        next_idx;

    logic                     s1_valid;
    logic                     s1_mode;
    logic signed [DATA_W-1:0] s1_base;
    logic signed [DATA_W-1:0] s1_next;
    logic [REM_W-1:0]         s1_rem;

    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_ext;
    logic signed [PROD_W-1:0] rem_ext;
    logic signed [PROD_W-1:0] prod;

    logic                     s2_valid;
    logic                     s2_mode;
    logic signed [DATA_W-1:0] s2_base;
    logic signed [PROD_W-1:0] s2_prod;
    logic signed [DATA_W-1:0] y_lin;

    // One stall signal freezes every stage at once, so no skid storage is needed.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Offsetting by half range turns the signed sample into an unsigned table coordinate.
    assign u        = in_x + BIAS;
    assign idx      = u[DATA_W-1 -: ADDR_W];
    assign next_idx = (idx == {ADDR_W{1'b1}}) ? idx : idx + 1'b1;

    // LUT writes are independent of the pipeline stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_we) begin
            lut[lut_addr] <= lut_data;
        end
    end

    // Stage 1: table read; a write in the same cycle lands after this read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_base  <= '0;
            s1_next  <= '0;
            s1_rem   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_mode  <= in_mode;
            s1_base  <= lut[idx];
            s1_next  <= lut[next_idx];
            s1_rem   <= u[REM_W-1:0];
        end
    end

    // Full-precision slope times fraction; the remainder is zero-extended so it stays positive.
    assign diff     = {s1_next[DATA_W-1], s1_next} - {s1_base[DATA_W-1], s1_base};
    assign diff_ext = {{(PROD_W-DATA_W-1){diff[DATA_W]}}, diff};
    assign rem_ext  = {{(PROD_W-REM_W){1'b0}}, s1_rem};
    assign prod     = diff_ext * rem_ext;

    // Stage 2: multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_base  <= '0;
            s2_prod  <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_base  <= s1_base;
            s2_prod  <= prod;
        end
    end

    // Arithmetic shift floors toward minus infinity; the sum wraps to the result width.
    assign y_lin = DATA_W'(PROD_W'(s2_base) + (s2_prod >>> REM_W));

    // Stage 3: add and register the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_y     <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            out_y     <= s2_mode ? s2_base : y_lin;
        end
    end

endmodule

// File: tb/tb_activation_interpolator_pipe.sv
// Randomized and directed checks of activation_interpolator_pipe against an arithmetic
// model of the table, interpolation and in-order delivery.
module tb_activation_interpolator_pipe;

    localparam int NOEXP = 99999;

    logic              clk = 1'b0;
    logic              rst;
    logic              lut_we;
    logic [3:0]        lut_addr;
    logic signed [7:0] lut_data;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_x;
    logic              in_mode;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_y;

    activation_interpolator_pipe #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int mlut [16];
    int exp_q [$];
    bit prev_ov = 1'b0;
    bit prev_or = 1'b0;
    int prev_y  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: table lookup with clamp, exact product, floor division by 16, 8-bit wrap.
    function automatic int model_y(input int x, input bit mode);
        int u, idx, rem, base, nxt, p, q, y;
        u    = x + 128;
        idx  = u / 16;
        rem  = u % 16;
        base = mlut[idx];
        nxt  = (idx == 15) ? base : mlut[idx + 1];
        if (mode) return base;
        p = (nxt - base) * rem;
        q = p / 16;
        if (p < 0 && (p % 16) != 0) q = q - 1;
        y = base + q;
        return ((y + 128) & 255) - 128;
    endfunction

    // One clock cycle: drive at the falling edge, sample and score before the rising edge.
    task automatic cycle(input bit v, input int x, input bit mode, input bit ordy,
                         input bit we, input int waddr, input int wdata,
                         input int force_exp, output bit acc);
        int e;
        logic [31:0] xv, dv;
        @(negedge clk);
        if (prev_ov && !prev_or) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_y", int'(out_y), prev_y);
        end
        xv = x;
        dv = wdata;
        in_valid  = v;
        in_x      = xv[7:0];
        in_mode   = mode;
        out_ready = ordy;
        lut_we    = we;
        lut_addr  = waddr[3:0];
        lut_data  = dv[7:0];
        #1;
        check("in_ready", int'(in_ready), int'(!out_valid || ordy));
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_y", int'(out_y), e);
            end
        end
        acc = v && in_ready;
        if (acc) exp_q.push_back(force_exp == NOEXP ? model_y(x, mode) : force_exp);
        if (we) mlut[waddr] = wdata;
        prev_ov = out_valid;
        prev_or = ordy;
        prev_y  = int'(out_y);
    endtask

    task automatic wr(input int a, input int d);
        bit acc;
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b1, a, d, NOEXP, acc);
    endtask

    task automatic send(input int x, input bit mode, input int force_exp);
        bit acc;
        cycle(1'b1, x, mode, 1'b1, 1'b0, 0, 0, force_exp, acc);
        check("send_acc", int'(acc), 1);
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0, NOEXP, acc);
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int xs [10];
        int i, cyc;

        rst = 1'b1; lut_we = 1'b0; lut_addr = '0; lut_data = '0;
        in_valid = 1'b0; in_x = '0; in_mode = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 16; k++) mlut[k] = 0;
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Interpolation and exact latency
        wr(8, 16);
        wr(9, 48);
        drain();
        cycle(1'b1, 8, 1'b0, 1'b1, 1'b0, 0, 0, 32, acc);
        check("lat_acc", int'(acc), 1);
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0, NOEXP, acc);
            check("lat_valid", int'(out_valid), (k == 3) ? 1 : 0);
        end

        // Negative slope floors toward minus infinity; step mode returns base
        wr(3, 40);
        wr(4, -23);
        send(-79, 1'b0, 36);
        send(-79, 1'b1, 40);

        // Range ends, top entry clamps
        wr(0, -100);
        wr(15, 90);
        send(-128, 1'b0, -100);
        send(127, 1'b0, 90);
        drain();

        // Back-to-back stream with a 4-cycle downstream stall
        for (int k = 0; k < 10; k++) xs[k] = $urandom_range(0, 255) - 128;
        i = 0;
        cyc = 0;
        while (i < 10 && cyc < 60) begin
            cycle(1'b1, xs[i], 1'(k_mode(i)), !(cyc >= 4 && cyc < 8), 1'b0, 0, 0, NOEXP, acc);
            if (acc) i++;
            cyc++;
        end
        check("bp_all_accepted", i, 10);
        drain();

        // Same-cycle write is not seen by the sample read in that cycle
        wr(5, 10);
        wr(6, 10);
        cycle(1'b1, -48, 1'b0, 1'b1, 1'b1, 5, 70, 10, acc);
        check("coll_acc", int'(acc), 1);
        send(-48, 1'b0, 70);
        drain();

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 255) - 128,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 15),
                  $urandom_range(0, 255) - 128, NOEXP, acc);
        end
        drain();

        // Reset with samples in flight
        for (int k = 0; k < 16; k++) wr(k, $urandom_range(1, 100));
        send(10, 1'b0, NOEXP);
        send(-20, 1'b0, NOEXP);
        send(50, 1'b1, NOEXP);
        @(negedge clk);
        #2;
        rst = 1'b1;
        in_valid = 1'b1;
        lut_we = 1'b1;
        lut_addr = 4'd3;
        lut_data = 8'sd55;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_y", int'(out_y), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        check("midrst_hold_valid", int'(out_valid), 0);
        check("midrst_hold_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        in_valid = 1'b0;
        lut_we = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 16; k++) mlut[k] = 0;
        prev_ov = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0, NOEXP, acc);
            check("post_rst_idle", int'(out_valid), 0);
        end
        send(-128, 1'b0, 0);
        send(-73, 1'b0, 0);
        send(0, 1'b1, 0);
        send(127, 1'b0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic int k_mode(input int n);
        return n % 3 == 2 ? 1 : 0;
    endfunction

endmodule

// File: doc/activation_interpolator_pipe.md
ACTIVATION_INTERPOLATOR_PIPE -- requirements
Module: activation_interpolator_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed width of input sample, LUT entries and result.
REQ-002 SHALL have parameter ADDR_W, default 4, LUT index width; depth = 2^ADDR_W; REM_W = DATA_W-ADDR_W SHALL be >= 1.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port lut_we  input  1  LUT write strobe.
REQ-006 SHALL have port lut_addr  input  ADDR_W  LUT write address.
REQ-007 SHALL have port lut_data  input  DATA_W  signed LUT write data.
REQ-008 SHALL have port in_valid  input  1  sample present.
REQ-009 SHALL have port in_ready  output  1  block accepts sample this cycle.
REQ-010 SHALL have port in_x  input  DATA_W  signed sample.
REQ-011 SHALL have port in_mode  input  1  0 = linear interpolation, 1 = step (nearest-lower entry).
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_y  output  DATA_W  signed result.

Function
REQ-015 SHALL hold a 2^ADDR_W x DATA_W signed register LUT, written on clk when lut_we=1.
REQ-016 SHALL map sample: u = in_x + 2^(DATA_W-1) (unsigned, DATA_W bits); idx = u[DATA_W-1 -: ADDR_W]; rem = u[REM_W-1:0].
REQ-017 SHALL read base = LUT[idx]; next = LUT[idx+1], except idx = 2^ADDR_W-1 SHALL use next = LUT[idx] (clamp, no wrap).
REQ-018 SHALL compute diff = next-base at DATA_W+1 bits signed, product diff*rem at DATA_W+REM_W+2 bits signed, no truncation.
REQ-019 SHALL compute y = base + (product >>> REM_W), arithmetic shift (floor toward minus infinity), truncated to DATA_W; with in_mode=1, y = base.
REQ-020 SHALL be a 3-stage pipeline: S1 capture x/mode and LUT read, S2 multiply, S3 add and register out_y; each stage carries a valid bit; in_mode travels with its sample.
REQ-021 SHALL use global advance = !out_valid || out_ready; in_ready = advance; all stages SHALL shift only when advance=1, else hold.
REQ-022 SHALL accept a sample when in_valid && in_ready; a non-accepted cycle inserts a bubble (valid=0) into S1.
REQ-023 SHALL have latency 3 cycles accept-to-out_valid with out_ready held high, and throughput 1 sample/cycle.
REQ-024 SHALL keep out_y and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL read the LUT in S1 on the accept cycle; a write to the same address in that cycle SHALL NOT be seen (old value used); writes SHALL be accepted regardless of pipeline stall.
REQ-026 SHALL produce results in acceptance order; no sample dropped or duplicated.

Reset
REQ-027 SHALL, while rst=1, asynchronously clear all stage valid bits, out_valid=0, out_y=0, all LUT entries=0, all pipeline data registers=0.
REQ-028 SHALL, on rst asserted mid-operation, discard all in-flight samples; in_ready SHALL read 1 during and after reset.
REQ-029 SHALL ignore lut_we and in_valid while rst=1.

Verification (DATA_W=8, ADDR_W=4)
REQ-030 SHALL verify interpolation: LUT[8]=16, LUT[9]=48, in_x=0x08 (idx 8, rem 8), mode 0 -> out_y=32 exactly 3 cycles after accept.
REQ-031 SHALL verify negative slope floor: LUT[3]=40, LUT[4]=-23, in_x=-79 (idx 3, rem 1) -> out_y=36; same with mode 1 -> out_y=40.
REQ-032 SHALL verify range ends: LUT[0]=-100, LUT[15]=90; in_x=-128 -> -100; in_x=127 (idx 15, rem 15) -> 90 (clamp).
REQ-033 SHALL verify backpressure: stream 10 samples back-to-back, out_ready=0 for 4 cycles mid-stream -> in_ready=0 while out_valid&&!out_ready, out_y held, all 10 results in order.
REQ-034 SHALL verify write/read collision: LUT[5]=10, LUT[6]=10; same cycle accept in_x with idx 5 and write LUT[5]=70 -> result 10; next sample idx 5 rem 0 -> 70.
REQ-035 SHALL verify reset mid-stream: rst pulse with 3 samples in flight -> out_valid=0, out_y=0, no stale result after release; LUT reads back 0 (all outputs 0).
